// File: rtl/i2s_pkg.sv
// Shared types for the I2S tone generator: default sample width, the
// request FSM states and the sine quadrant encoding.
package i2s_pkg;

  localparam int I2S_DATA_BIT = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_READ  = 3'd2,
    ST_SCALE = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  // Bit 0 set: descending half of the quarter (mirror the ROM index).
  // Bit 1 set: negative half-cycle (negate the ROM value).
  typedef enum logic [1:0] {
    Q_RISE     = 2'd0,
    Q_FALL     = 2'd1,
    Q_NEG_RISE = 2'd2,
    Q_NEG_FALL = 2'd3
  } quad_t;

endpackage

// File: rtl/i2s_tone_gen_if.sv
// Request/sample bundle between the tone generator and the I2S CDC write side.
interface i2s_tone_gen_if #(
  parameter int DATA_BIT  = i2s_pkg::I2S_DATA_BIT,
  parameter int PHASE_BIT = 24
);
  logic                       enable;
  logic [PHASE_BIT-1:0]       phase_inc;
  logic [3:0]                 vol_l;
  logic [3:0]                 vol_r;
  logic                       wr_ready;
  logic signed [DATA_BIT-1:0] audio_l;
  logic signed [DATA_BIT-1:0] audio_r;
  logic                       wr_en;
  logic                       busy;
  logic [7:0]                 missed_cnt;

  modport master (
    input  enable, phase_inc, vol_l, vol_r, wr_ready,
    output audio_l, audio_r, wr_en, busy, missed_cnt
  );

  modport slave (
    output enable, phase_inc, vol_l, vol_r, wr_ready,
    input  audio_l, audio_r, wr_en, busy, missed_cnt
  );
endinterface

// File: rtl/sine_rom.sv
// Quarter-wave sine ROM with synchronous read; entries are sampled at
// bin centres so every value is strictly positive.
module sine_rom #(
  parameter int LUT_BIT  = 8,
  parameter int DATA_BIT = 16
) (
  input  logic                clk,
  input  logic [LUT_BIT-1:0]  addr,
  output logic [DATA_BIT-1:0] data
);

  localparam int DEPTH = 1 << LUT_BIT;

  // Elaboration-time Taylor series keeps the table free of tool math calls.
  function automatic logic [DATA_BIT-1:0] rom_value(input int i);
    real x;
    real term;
    real acc;
    real amp;
    x    = 1.5707963267948966 * (real'(i) + 0.5) / real'(DEPTH);
    term = x;
    acc  = x;
    for (int k = 1; k < 12; k++) begin
      term = -term * x * x / real'((2 * k) * (2 * k + 1));
      acc  = acc + term;
    end
    amp = real'((64'd1 << (DATA_BIT - 1)) - 64'd1);
    return DATA_BIT'($rtoi(amp * acc + 0.5));
  endfunction

  logic [DATA_BIT-1:0] rom_tbl [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    localparam logic [DATA_BIT-1:0] VALUE = rom_value(i);
    assign rom_tbl[i] = VALUE;
  end

  always_ff @(posedge clk) begin
    data <= rom_tbl[addr];
  end

endmodule

// File: rtl/i2s_tone_gen.sv
// Sine tone generator answering one-cycle sample requests from the I2S CDC
// stage with a volume-scaled stereo sample and a single write strobe.
module i2s_tone_gen
  import i2s_pkg::*;
#(
  parameter int DATA_BIT  = I2S_DATA_BIT,
  parameter int PHASE_BIT = 24,
  parameter int LUT_BIT   = 8
) (
  input logic            clk,
  input logic            reset,
  i2s_tone_gen_if.master bus
);

  state_t                     state;
  logic [PHASE_BIT-1:0]       phase;
  logic [PHASE_BIT-1:0]       inc_cap;
  logic [3:0]                 vol_l_cap;
  logic [3:0]                 vol_r_cap;
  logic                       en_cap;
  quad_t                      quad_p0;
  logic [LUT_BIT-1:0]         addr_p0;
  logic [DATA_BIT-1:0]        rom_p1;
  logic signed [DATA_BIT-1:0] raw_p1;
  logic signed [DATA_BIT-1:0] audio_l;
  logic signed [DATA_BIT-1:0] audio_r;
  logic                       wr_en;
  logic                       busy;
  logic [7:0]                 missed_cnt;
  quad_t                      quad_cur;
  logic [LUT_BIT-1:0]         idx_cur;

  function automatic logic signed [DATA_BIT-1:0] attenuate(
    input logic signed [DATA_BIT-1:0] x,
    input logic [3:0]                 sh
  );
    return x >>> sh;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] x);
    return (x == 8'hFF) ? x : x + 8'd1;
  endfunction

  assign quad_cur = quad_t'(phase[PHASE_BIT-1 -: 2]);
  assign idx_cur  = phase[PHASE_BIT-3 -: LUT_BIT];

  sine_rom #(
    .LUT_BIT  (LUT_BIT),
    .DATA_BIT (DATA_BIT)
  ) u_rom (
    .clk  (clk),
    .addr (addr_p0),
    .data (rom_p1)
  );

  // ROM magnitude is at most 2^(DATA_BIT-1)-1, so negation cannot overflow.
  assign raw_p1 = quad_p0[1] ? -$signed(rom_p1) : $signed(rom_p1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      inc_cap    <= '0;
      vol_l_cap  <= '0;
      vol_r_cap  <= '0;
      en_cap     <= 1'b0;
      quad_p0    <= Q_RISE;
      addr_p0    <= '0;
      audio_l    <= '0;
      audio_r    <= '0;
      wr_en      <= 1'b0;
      busy       <= 1'b0;
      missed_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      if (bus.wr_ready && state != ST_IDLE) begin
        missed_cnt <= sat_inc(missed_cnt);
      end
      unique case (state)
        ST_IDLE: begin
          if (bus.wr_ready) begin
            inc_cap   <= bus.phase_inc;
            vol_l_cap <= bus.vol_l;
            vol_r_cap <= bus.vol_r;
            en_cap    <= bus.enable;
            busy      <= 1'b1;
            state     <= ST_ADDR;
          end
        end
        // p0: quadrant decode and mirrored ROM address
        ST_ADDR: begin
          quad_p0 <= quad_cur;
          addr_p0 <= quad_cur[0] ? ~idx_cur : idx_cur;
          state   <= ST_READ;
        end
        // p1: ROM output registers inside sine_rom
        ST_READ: begin
          state <= ST_SCALE;
        end
        // p2: sign, attenuation and output registers
        ST_SCALE: begin
          if (en_cap) begin
            audio_l <= attenuate(raw_p1, vol_l_cap);
            audio_r <= attenuate(raw_p1, vol_r_cap);
          end else begin
            audio_l <= '0;
            audio_r <= '0;
          end
          wr_en <= 1'b1;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          phase <= en_cap ? phase + inc_cap : '0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.audio_l    = audio_l;
  assign bus.audio_r    = audio_r;
  assign bus.wr_en      = wr_en;
  assign bus.busy       = busy;
  assign bus.missed_cnt = missed_cnt;

endmodule

// File: tb/tb_i2s_tone_gen.sv
// Bench for i2s_tone_gen: fixed tone vectors, random requests against a
// 1024-point sine model, and the drop / saturation / reset corner cases.
module tb_i2s_tone_gen;

  localparam real PI = 3.14159265358979323846;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic [23:0] phase_m;

  i2s_tone_gen_if #(.DATA_BIT(16), .PHASE_BIT(24)) bus ();

  i2s_tone_gen #(.DATA_BIT(16), .PHASE_BIT(24), .LUT_BIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit          en;
    logic [23:0] inc;
    int          vl;
    int          vr;
    int          el;
    int          er;
  } vec_t;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Ideal 1024-point sine sampled at bin centres, rounded half away from zero.
  function automatic int tone(input logic [23:0] ph);
    int  k;
    real v;
    int  mag;
    k   = int'(ph >> 14);
    v   = 32767.0 * $sin(2.0 * PI * (real'(k) + 0.5) / 1024.0);
    mag = $rtoi(((v < 0.0) ? -v : v) + 0.5);
    return (v < 0.0) ? -mag : mag;
  endfunction

  function automatic int atten(input int x, input int sh);
    return $rtoi($floor(real'(x) / (2.0 ** sh)));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.wr_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    phase_m = '0;
  endtask

  // One request from IDLE; checks the strobe lands on the 3rd edge after acceptance.
  task automatic do_request(input bit en, input logic [23:0] inc, input int vl,
                            input int vr, output int got_l, output int got_r);
    int hits;
    int first;
    hits  = 0;
    first = 0;
    got_l = 0;
    got_r = 0;
    bus.enable    = en;
    bus.phase_inc = inc;
    bus.vol_l     = 4'(vl);
    bus.vol_r     = 4'(vr);
    bus.wr_ready  = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (bus.wr_en === 1'b1) begin
        hits++;
        if (first == 0) begin
          first = t;
          got_l = int'($signed(bus.audio_l));
          got_r = int'($signed(bus.audio_r));
        end
      end
    end
    check("wr_en_count", hits, 1);
    check("wr_en_latency", first, 3);
  endtask

  vec_t vecs[17];
  int   gl, gr, el, er, hits, first, prev;
  bit   wrapped;
  bit   en_r;
  logic [23:0] inc_r;
  int   vl_r, vr_r;

  initial begin
    total = 0;
    bad   = 0;
    bus.enable    = 1'b0;
    bus.phase_inc = '0;
    bus.vol_l     = '0;
    bus.vol_r     = '0;
    bus.wr_ready  = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 8; i++) begin
      el = (i % 4 == 0) ? 101 : (i % 4 == 1) ? 32767 : (i % 4 == 2) ? -101 : -32767;
      vecs[i] = '{1'b1, 24'h400000, 0, 0, el, el};
    end
    vecs[8]  = '{1'b1, 24'h400000, 0, 2, 101, 25};
    vecs[9]  = '{1'b1, 24'h400000, 0, 2, 32767, 8191};
    vecs[10] = '{1'b1, 24'h400000, 0, 2, -101, -26};
    vecs[11] = '{1'b1, 24'h400000, 0, 2, -32767, -8192};
    vecs[12] = '{1'b1, 24'h123456, 0, 0, 101, 101};
    vecs[13] = '{1'b0, 24'h400000, 0, 0, 0, 0};
    vecs[14] = '{1'b0, 24'h400000, 3, 5, 0, 0};
    vecs[15] = '{1'b0, 24'h400000, 0, 0, 0, 0};
    vecs[16] = '{1'b1, 24'h400000, 0, 0, 101, 101};

    do_reset();
    check("rst_audio_l", int'($signed(bus.audio_l)), 0);
    check("rst_audio_r", int'($signed(bus.audio_r)), 0);
    check("rst_wr_en", int'(bus.wr_en), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_missed", int'(bus.missed_cnt), 0);

    // Fixed vectors: quarter-turn tone, right-channel attenuation, enable gating.
    for (int i = 0; i < 17; i++) begin
      do_request(vecs[i].en, vecs[i].inc, vecs[i].vl, vecs[i].vr, gl, gr);
      check($sformatf("vec%0d_l", i), gl, vecs[i].el);
      check($sformatf("vec%0d_r", i), gr, vecs[i].er);
      phase_m = vecs[i].en ? phase_m + vecs[i].inc : 24'h0;
      repeat (11) tick();
    end

    // Random requests against the model.
    for (int i = 0; i < 60; i++) begin
      en_r  = ($urandom_range(0, 7) != 0);
      inc_r = 24'($urandom);
      vl_r  = $urandom_range(0, 15);
      vr_r  = $urandom_range(0, 15);
      el = en_r ? atten(tone(phase_m), vl_r) : 0;
      er = en_r ? atten(tone(phase_m), vr_r) : 0;
      do_request(en_r, inc_r, vl_r, vr_r, gl, gr);
      check($sformatf("rnd%0d_l", i), gl, el);
      check($sformatf("rnd%0d_r", i), gr, er);
      phase_m = en_r ? phase_m + inc_r : 24'h0;
      repeat ($urandom_range(0, 4)) tick();
    end

    // Second request two cycles after the first is dropped.
    do_reset();
    bus.enable = 1'b1;
    bus.phase_inc = 24'h400000;
    bus.vol_l = '0;
    bus.vol_r = '0;
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    hits = 0;
    first = 0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      bus.wr_ready = (t == 1);
      if (bus.wr_en === 1'b1) begin
        hits++;
        if (first == 0) first = t;
      end
    end
    bus.wr_ready = 1'b0;
    check("drop_wr_en_count", hits, 1);
    check("drop_wr_en_latency", first, 3);
    check("drop_missed", int'(bus.missed_cnt), 1);

    // Continuous requests drive missed_cnt into saturation.
    prev = int'(bus.missed_cnt);
    wrapped = 1'b0;
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 420; i++) begin
      tick();
      if (int'(bus.missed_cnt) < prev) wrapped = 1'b1;
      prev = int'(bus.missed_cnt);
    end
    bus.wr_ready = 1'b0;
    repeat (6) tick();
    check("sat_no_wrap", int'(wrapped), 0);
    check("sat_missed", int'(bus.missed_cnt), 255);

    // Reset while the sample is in READ.
    do_reset();
    do_request(1'b1, 24'h400000, 0, 0, gl, gr);
    check("pre_rst_l", gl, 101);
    phase_m = 24'h400000;
    repeat (4) tick();
    hits = 0;
    bus.wr_ready = 1'b1;
    tick();
    bus.wr_ready = 1'b0;
    tick();
    check("mid_busy", int'(bus.busy), 1);
    reset = 1'b1;
    bus.wr_ready = 1'b1;
    tick();
    if (bus.wr_en === 1'b1) hits++;
    bus.wr_ready = 1'b0;
    tick();
    if (bus.wr_en === 1'b1) hits++;
    reset = 1'b0;
    phase_m = '0;
    check("mid_rst_audio_l", int'($signed(bus.audio_l)), 0);
    check("mid_rst_audio_r", int'($signed(bus.audio_r)), 0);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_missed", int'(bus.missed_cnt), 0);
    for (int t = 0; t < 8; t++) begin
      tick();
      if (bus.wr_en === 1'b1) hits++;
    end
    check("mid_rst_no_wr_en", hits, 0);
    do_request(1'b1, 24'h400000, 0, 1, gl, gr);
    check("post_rst_l", gl, 101);
    check("post_rst_r", gr, 50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
